// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Data field is sized for the widest (9-bit) frame; narrower words are zero-extended.
  typedef struct packed {
    logic       brk;
    logic       ferr;
    logic       perr;
    logic [8:0] data;
  } rx_word_t;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO with occupancy output. A push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      pop,
  output logic [WIDTH-1:0]          rdata,
  output logic                      valid,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign valid   = (level != '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  // Head is forced to zero when empty so the outputs read 0 after reset.
  assign rdata   = valid ? mem[rd_ptr] : '0;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage array; contents need no reset because valid gates the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: synchronise, re-align on each start edge, majority-vote
// around mid-bit, flag parity/framing/break errors, buffer words in a FIFO.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int    CLK_DIV    = 434,
  parameter int    DATA_BITS  = 8,
  parameter string PARITY     = "NONE",
  parameter int    STOP_BITS  = 1,
  parameter int    FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_uart_rx,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          m_perr,
  output logic                          m_ferr,
  output logic                          m_brk,
  output logic                          o_overflow,
  input  logic                          i_clr_ovf,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int PMODE = (PARITY == "ODD")  ? PAR_ODD  :
                         (PARITY == "EVEN") ? PAR_EVEN : PAR_NONE;
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  if (CLK_DIV < 8) begin : g_bad_div
    $error("uart_rx_frame: CLK_DIV must be >= 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_rx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY != "NONE" && PARITY != "ODD" && PARITY != "EVEN") begin : g_bad_par
    $error("uart_rx_frame: PARITY must be NONE, ODD or EVEN");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_rx_frame: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_frame: FIFO_DEPTH must be a power of two >= 2");
  end

  logic                 sync1, sync2, prev;
  logic [2:0]           samp;
  rx_state_t            state, state_nx;
  logic [CW-1:0]        cyc;
  logic [3:0]           idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_r, par_r, ferr_r;
  logic                 start_edge, tick, bit_val;
  logic                 push, fifo_full, ovf_set;
  rx_word_t             word, head;
  logic                 head_unused;

  assign start_edge = prev & ~sync2;
  assign tick       = (state != S_IDLE) && (cyc == HALF);
  assign bit_val    = maj3(samp);
  assign o_busy     = (state != S_IDLE);

  // Line synchroniser, start-edge history and the 3-sample vote window.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b0;
      samp  <= 3'b111;
    end else begin
      sync1 <= i_uart_rx;
      sync2 <= sync1;
      prev  <= sync2;
      samp  <= {samp[1:0], sync2};
    end
  end

  // Bit-period counter: held at 0 in IDLE so every start edge re-aligns timing.
  always_ff @(posedge clk) begin
    if (rst || state == S_IDLE) cyc <= '0;
    else if (cyc == LAST)       cyc <= '0;
    else                        cyc <= cyc + 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state, word assembly and push strobe (push happens on the last stop sample).
  always_comb begin
    state_nx  = state;
    push      = 1'b0;
    word      = '0;
    word.data = 9'(shreg);
    word.perr = perr_r;
    word.ferr = ferr_r | ~bit_val;
    word.brk  = word.ferr && (shreg == '0) && (PMODE == PAR_NONE || !par_r);
    case (state)
      S_IDLE:      if (start_edge) state_nx = S_START;
      S_START:     if (tick) state_nx = bit_val ? S_IDLE : S_DATA;
      S_DATA:      if (tick && idx == 4'(DATA_BITS - 1))
                     state_nx = (PMODE == PAR_NONE) ? S_STOP : S_PARITY;
      S_PARITY:    if (tick) state_nx = S_STOP;
      S_STOP:      if (tick && idx == 4'(STOP_BITS - 1)) begin
                     push     = 1'b1;
                     state_nx = word.ferr ? S_WAIT_HIGH : S_IDLE;
                   end
      S_WAIT_HIGH: if (sync2) state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  // Per-sample datapath: LSB-first shift, parity check, stop-bit accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      shreg  <= '0;
      perr_r <= 1'b0;
      par_r  <= 1'b0;
      ferr_r <= 1'b0;
    end else if (tick) begin
      case (state)
        S_START: begin
          idx    <= '0;
          perr_r <= 1'b0;
          par_r  <= 1'b0;
          ferr_r <= 1'b0;
        end
        S_DATA: begin
          shreg <= {bit_val, shreg[DATA_BITS-1:1]};
          idx   <= (idx == 4'(DATA_BITS - 1)) ? 4'd0 : idx + 4'd1;
        end
        S_PARITY: begin
          par_r  <= bit_val;
          perr_r <= ((^shreg) ^ bit_val) != (PMODE == PAR_ODD);
        end
        S_STOP: begin
          if (!bit_val) ferr_r <= 1'b1;
          idx <= idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  uart_rx_fifo #(
    .WIDTH ($bits(rx_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (word),
    .pop   (m_ready),
    .rdata (head),
    .valid (m_valid),
    .full  (fifo_full),
    .level (o_level)
  );

  assign m_data      = head.data[DATA_BITS-1:0];
  assign m_perr      = head.perr;
  assign m_ferr      = head.ferr;
  assign m_brk       = head.brk;
  // Upper data bits are always zero for narrow frames.
  assign head_unused = ^head.data;

  assign ovf_set = push && fifo_full && !(m_valid && m_ready);

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (rst)            o_overflow <= 1'b0;
    else if (ovf_set)   o_overflow <= 1'b1;
    else if (i_clr_ovf) o_overflow <= 1'b0;
  end

endmodule
